// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_pkg
// Brief   : Shared fetch-state encoding and default fetch geometry.
// Revision: 1.0
// ============================================================================
package cpu_pkg;

    localparam int DEF_ADDR_W      = 9;
    localparam int DEF_BYTE_W      = 8;
    localparam int DEF_INSTR_BYTES = 4;
    localparam int INSTR_W         = DEF_INSTR_BYTES * DEF_BYTE_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_byte_assembler.sv
`default_nettype none
// ============================================================================
// Module  : fetch_byte_assembler
// Brief   : Packs returned memory bytes little-endian into one instruction word.
// Revision: 1.0
// ============================================================================
module fetch_byte_assembler
    import cpu_pkg::*;
#(
    parameter int BYTE_W      = DEF_BYTE_W,
    parameter int INSTR_BYTES = DEF_INSTR_BYTES
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_clear,
    input  logic                          i_byte_valid,
    input  logic [BYTE_W-1:0]             i_byte,
    output logic [INSTR_BYTES*BYTE_W-1:0] o_word,
    output logic                          o_done
);

    localparam int c_CNT_W = $clog2(INSTR_BYTES + 1);

    logic [c_CNT_W-1:0]            r_cnt;
    logic [INSTR_BYTES*BYTE_W-1:0] r_word;
    logic                          w_last;

    assign w_last = (r_cnt == c_CNT_W'(INSTR_BYTES - 1));
    // A clear in the same cycle as a returning byte wins, so a stale byte never completes a word
    assign o_done = i_byte_valid && !i_clear && w_last;
    assign o_word = r_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_byte_valid) begin
            for (int k = 0; k < INSTR_BYTES; k++) begin
                if (r_cnt == c_CNT_W'(k)) begin
                    r_word[k*BYTE_W +: BYTE_W] <= i_byte;
                end
            end
            r_cnt <= w_last ? '0 : r_cnt + c_CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch_unit
// Brief   : PC owner and byte-serial instruction fetcher with valid/ready output.
// Revision: 1.0
// ============================================================================
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W      = DEF_ADDR_W,
    parameter int                BYTE_W      = DEF_BYTE_W,
    parameter int                INSTR_BYTES = DEF_INSTR_BYTES,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
)(
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          fetch_en,
    input  logic                          redirect_valid,
    input  logic [ADDR_W-1:0]             redirect_pc,
    output logic                          mem_rd_en,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic [BYTE_W-1:0]             mem_rdata,
    output logic                          instr_valid,
    input  logic                          instr_ready,
    output logic [INSTR_BYTES*BYTE_W-1:0] instr,
    output logic [ADDR_W-1:0]             instr_pc,
    output logic [ADDR_W-1:0]             pc
);

    localparam int c_CNT_W = $clog2(INSTR_BYTES + 1);

    fetch_state_t        r_state, w_nxt_state;
    logic [ADDR_W-1:0]   r_pc, w_nxt_pc;
    logic [c_CNT_W-1:0]  r_issue, w_nxt_issue;
    logic                r_rd_en, w_nxt_rd_en;
    logic [ADDR_W-1:0]   r_addr, w_nxt_addr;
    logic                r_valid, w_nxt_valid;
    logic [ADDR_W-1:0]   r_instr_pc, w_nxt_instr_pc;
    logic                r_pipe;
    logic                w_done;
    logic                w_hs;

    assign w_hs = r_valid && instr_ready;

    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_pc       = r_pc;
        w_nxt_issue    = r_issue;
        w_nxt_rd_en    = 1'b0;
        w_nxt_addr     = r_addr;
        w_nxt_valid    = r_valid;
        w_nxt_instr_pc = r_instr_pc;

        if (redirect_valid) begin
            w_nxt_pc    = redirect_pc;
            w_nxt_issue = '0;
            w_nxt_valid = 1'b0;
            w_nxt_state = fetch_en ? ST_FETCH : ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (fetch_en) begin
                        w_nxt_state = ST_FETCH;
                        w_nxt_rd_en = 1'b1;
                        w_nxt_addr  = r_pc;
                        w_nxt_issue = c_CNT_W'(1);
                    end
                end
                ST_FETCH: begin
                    if (r_issue < c_CNT_W'(INSTR_BYTES)) begin
                        w_nxt_rd_en = 1'b1;
                        w_nxt_addr  = r_pc + ADDR_W'(r_issue);
                        w_nxt_issue = r_issue + c_CNT_W'(1);
                    end
                    if (w_done) begin
                        w_nxt_valid    = 1'b1;
                        w_nxt_instr_pc = r_pc;
                        w_nxt_pc       = r_pc + ADDR_W'(INSTR_BYTES);
                        w_nxt_issue    = '0;
                        w_nxt_state    = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Next fetch starts on the handshake edge so no idle cycle is lost
                    if (w_hs) begin
                        w_nxt_valid = 1'b0;
                        if (fetch_en) begin
                            w_nxt_state = ST_FETCH;
                            w_nxt_rd_en = 1'b1;
                            w_nxt_addr  = r_pc;
                            w_nxt_issue = c_CNT_W'(1);
                        end else begin
                            w_nxt_state = ST_IDLE;
                        end
                    end
                end
                default: begin
                    w_nxt_state = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state    <= ST_IDLE;
            r_pc       <= RESET_PC;
            r_issue    <= '0;
            r_rd_en    <= 1'b0;
            r_addr     <= RESET_PC;
            r_valid    <= 1'b0;
            r_instr_pc <= '0;
            r_pipe     <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_pc       <= w_nxt_pc;
            r_issue    <= w_nxt_issue;
            r_rd_en    <= w_nxt_rd_en;
            r_addr     <= w_nxt_addr;
            r_valid    <= w_nxt_valid;
            r_instr_pc <= w_nxt_instr_pc;
            r_pipe     <= r_rd_en && !redirect_valid;
        end
    end

    fetch_byte_assembler #(
        .BYTE_W      (BYTE_W),
        .INSTR_BYTES (INSTR_BYTES)
    ) u_asm (
        .clk          (CLK),
        .rst          (RESET),
        .i_clear      (redirect_valid),
        .i_byte_valid (r_pipe),
        .i_byte       (mem_rdata),
        .o_word       (instr),
        .o_done       (w_done)
    );

    assign mem_rd_en   = r_rd_en;
    assign mem_addr    = r_addr;
    assign instr_valid = r_valid;
    assign instr_pc    = r_instr_pc;
    assign pc          = r_pc;

endmodule
`default_nettype wire
